// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised Fibonacci/Galois LFSR pseudo-random source with
//                runtime seed load, zero-state recovery, valid/ready output
//                stream and a step counter that flags sequence wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int                 WIDTH = 8,
    parameter int                 MODE  = 0,
    parameter logic [WIDTH-1:0]   TAPS  = WIDTH'('hB8),
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'('h01)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             wrap_q,  wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] w_next;
    logic             w_fire;

    // A value is consumed only when offered, accepted and not pre-empted by a load.
    assign w_fire = valid_q && ready_i && !load_i;

    // Successor of the current state for the selected LFSR structure.
    generate
        if (MODE == 0) begin : g_fib
            logic w_fb;
            assign w_fb   = ^(state_q & TAPS);
            assign w_next = {state_q[WIDTH-2:0], w_fb};
        end else begin : g_gal
            assign w_next = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? TAPS : C_ZERO);
        end
    endgenerate

    // Next-state selection: load beats fire; a zero successor falls back to SEED.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        valid_d  = en_i && !load_i;

        if (load_i) begin
            count_d = C_ZERO;
            if (seed_i == C_ZERO) begin
                state_d  = SEED;
                start_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = seed_i;
                start_d = seed_i;
            end
        end else if (w_fire) begin
            if (w_next == C_ZERO) begin
                state_d  = SEED;
                start_d  = SEED;
                count_d  = C_ZERO;
                lockup_d = 1'b1;
            end else if (w_next == start_q) begin
                state_d = w_next;
                count_d = C_ZERO;
                wrap_d  = 1'b1;
            end else begin
                state_d = w_next;
                count_d = count_q + C_ONE;
            end
        end
    end

    // State registers with synchronous reset to the SEED start point.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            start_q  <= SEED;
            count_q  <= C_ZERO;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign data_o   = state_q;
    assign valid_o  = valid_q;
    assign count_o  = count_q;
    assign wrap_o   = wrap_q;
    assign lockup_o = lockup_q;

endmodule
`default_nettype wire
